// File: rtl/perf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : perf_pkg
// Purpose  : Shared types, constants and helpers for stream_perf_counter.
// Revision : 1.0 - initial release
// ============================================================================
package perf_pkg;

  localparam int SEQ_W  = 16;
  localparam int DROP_W = 16;

  // Counting state machine encoding
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } perf_state_e;

  // Width-independent part of a result record; the top module wraps it
  // together with the parameter-sized cycle and event fields.
  typedef struct packed {
    logic [SEQ_W-1:0]  seq;
    logic [DROP_W-1:0] dropped;
  } perf_tag_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [DROP_W-1:0] sat_inc_drop(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/perf_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : perf_sat_counter
// Purpose  : Saturating event counter with synchronous clear. Exposes the
//            value including the current cycle's event so a window snapshot
//            can capture it on the same edge the counter clears.
// Revision : 1.0 - initial release
// ============================================================================
module perf_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count_next
);

  logic [WIDTH-1:0] r_count;

  // Value after this cycle's event, held at all-ones once saturated
  always_comb begin
    count_next = r_count;
    if (inc && !(&r_count)) begin
      count_next = r_count + WIDTH'(1);
    end
  end

  // Counter register; clear wins over increment
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else begin
      r_count <= count_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_perf_counter.sv
`default_nettype none
// ============================================================================
// Module   : stream_perf_counter
// Purpose  : Passive per-window transfer/stall/idle counter for one
//            valid/ready stream; publishes one record per window on a
//            registered valid/ready result port.
// Revision : 1.0 - initial release
// ============================================================================
module stream_perf_counter
  import perf_pkg::*;
#(
  parameter int WINDOW_W       = 32,
  parameter int COUNT_W        = 32,
  parameter int DEFAULT_WINDOW = 1000
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                enable,
  input  logic [WINDOW_W-1:0] window_len,
  input  logic                window_len_load,
  input  logic                mon_valid,
  input  logic                mon_ready,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [WINDOW_W-1:0] res_cycles,
  output logic [COUNT_W-1:0]  res_xfers,
  output logic [COUNT_W-1:0]  res_stalls,
  output logic [COUNT_W-1:0]  res_idle,
  output logic [15:0]         res_seq,
  output logic [15:0]         res_dropped
);

  localparam logic [WINDOW_W-1:0] c_default_win = WINDOW_W'(DEFAULT_WINDOW);

  typedef struct packed {
    logic [WINDOW_W-1:0] cycles;
    logic [COUNT_W-1:0]  xfers;
    logic [COUNT_W-1:0]  stalls;
    logic [COUNT_W-1:0]  idle;
    perf_tag_t           tag;
  } rec_t;

  perf_state_e         r_state, w_state_next;
  logic [WINDOW_W-1:0] r_win, r_act_len, r_cyc;
  logic [WINDOW_W-1:0] w_win_next, w_cyc_next;
  logic [SEQ_W-1:0]    r_seq;
  logic [DROP_W-1:0]   r_drop;
  rec_t                r_rec;
  logic                r_res_valid;
  logic                w_counting, w_win_end, w_win_start, w_overrun, w_deliver, w_clear;
  logic [COUNT_W-1:0]  w_xfer_n, w_stall_n, w_idle_n;

  // A zero length would never end a window, so it is stored as one
  assign w_win_next  = window_len_load ? ((window_len == '0) ? WINDOW_W'(1) : window_len)
                                       : r_win;
  assign w_counting  = (r_state == COUNT) && enable;
  assign w_cyc_next  = r_cyc + WINDOW_W'(1);
  assign w_win_end   = w_counting && (w_cyc_next == r_act_len);
  assign w_win_start = ((r_state == IDLE) && enable) || w_win_end;
  assign w_overrun   = w_win_end && r_res_valid && !res_ready;
  assign w_deliver   = w_win_end && !w_overrun;
  assign w_clear     = !w_counting || w_win_end;

  // Next-state logic: enable alone moves between idle and counting
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (enable)  w_state_next = COUNT;
      COUNT:   if (!enable) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // Programmed length plus the length latched for the window in progress
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_win     <= c_default_win;
      r_act_len <= c_default_win;
    end else begin
      r_win <= w_win_next;
      if (w_win_start) r_act_len <= w_win_next;
    end
  end

  // Cycle count within the window; restarts on the window-end edge
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)      r_cyc <= '0;
    else if (w_clear) r_cyc <= '0;
    else              r_cyc <= w_cyc_next;
  end

  perf_sat_counter #(.WIDTH(COUNT_W)) u_xfer (
    .clk(clk), .nreset(nreset), .inc(w_counting && mon_valid && mon_ready),
    .clear(w_clear), .count_next(w_xfer_n)
  );
  perf_sat_counter #(.WIDTH(COUNT_W)) u_stall (
    .clk(clk), .nreset(nreset), .inc(w_counting && mon_valid && !mon_ready),
    .clear(w_clear), .count_next(w_stall_n)
  );
  perf_sat_counter #(.WIDTH(COUNT_W)) u_idle (
    .clk(clk), .nreset(nreset), .inc(w_counting && !mon_valid),
    .clear(w_clear), .count_next(w_idle_n)
  );

  // Sequence advances on every window end; drops accumulate until a snapshot
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_seq  <= '0;
      r_drop <= '0;
    end else begin
      if (w_win_end) r_seq <= r_seq + SEQ_W'(1);
      if (w_overrun)      r_drop <= sat_inc_drop(r_drop);
      else if (w_deliver) r_drop <= '0;
    end
  end

  // Result record: snapshot on delivery, hold until accepted
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_rec       <= '0;
      r_res_valid <= 1'b0;
    end else if (w_deliver) begin
      r_rec.cycles      <= w_cyc_next;
      r_rec.xfers       <= w_xfer_n;
      r_rec.stalls      <= w_stall_n;
      r_rec.idle        <= w_idle_n;
      r_rec.tag.seq     <= r_seq;
      r_rec.tag.dropped <= r_drop;
      r_res_valid       <= 1'b1;
    end else if (res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign res_valid   = r_res_valid;
  assign res_cycles  = r_rec.cycles;
  assign res_xfers   = r_rec.xfers;
  assign res_stalls  = r_rec.stalls;
  assign res_idle    = r_rec.idle;
  assign res_seq     = r_rec.tag.seq;
  assign res_dropped = r_rec.tag.dropped;

endmodule
`default_nettype wire

// File: tb/tb_stream_perf_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_stream_perf_counter
// Purpose  : Randomized scoreboard bench for stream_perf_counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_perf_counter;

  localparam int WW   = 16;
  localparam int CW   = 4;
  localparam int DEFW = 30;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          enable = 1'b0;
  logic [WW-1:0] window_len = '0;
  logic          window_len_load = 1'b0;
  logic          mon_valid = 1'b0;
  logic          mon_ready = 1'b0;
  logic          res_ready = 1'b0;
  logic          res_valid;
  logic [WW-1:0] res_cycles;
  logic [CW-1:0] res_xfers, res_stalls, res_idle;
  logic [15:0]   res_seq, res_dropped;

  stream_perf_counter #(.WINDOW_W(WW), .COUNT_W(CW), .DEFAULT_WINDOW(DEFW)) dut (
    .clk(clk), .nreset(nreset), .enable(enable), .window_len(window_len),
    .window_len_load(window_len_load), .mon_valid(mon_valid), .mon_ready(mon_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_cycles(res_cycles),
    .res_xfers(res_xfers), .res_stalls(res_stalls), .res_idle(res_idle),
    .res_seq(res_seq), .res_dropped(res_dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc; int x; int s; int i; int seq; int drop;
  } rec_t;

  rec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: window bookkeeping with plain integers
  bit m_counting = 0;
  bit m_pending  = 0;
  int m_win = DEFW, m_act = DEFW;
  int m_cyc = 0, m_x = 0, m_s = 0, m_i = 0, m_seq = 0, m_drop = 0;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_counting = 0; m_pending = 0; m_win = DEFW; m_act = DEFW;
    m_cyc = 0; m_x = 0; m_s = 0; m_i = 0; m_seq = 0; m_drop = 0;
    exp_q.delete();
  endtask

  always @(posedge clk) begin : b_model
    int   new_win;
    bit   delivered;
    rec_t r;
    if (!nreset) begin
      model_reset();
    end else begin
      new_win   = window_len_load ? ((window_len == 0) ? 1 : int'(window_len)) : m_win;
      delivered = 0;
      if (!m_counting) begin
        if (enable) begin
          m_counting = 1; m_act = new_win;
          m_cyc = 0; m_x = 0; m_s = 0; m_i = 0;
        end
      end else if (!enable) begin
        m_counting = 0;
        m_cyc = 0; m_x = 0; m_s = 0; m_i = 0;
      end else begin
        m_cyc++;
        if (mon_valid && mon_ready) m_x++;
        else if (mon_valid)         m_s++;
        else                        m_i++;
        if (m_cyc == m_act) begin
          if (m_pending && !res_ready) begin
            m_drop = sat(m_drop + 1, 65535);
          end else begin
            r = '{cyc: m_cyc, x: sat(m_x, CMAX), s: sat(m_s, CMAX), i: sat(m_i, CMAX),
                  seq: m_seq, drop: m_drop};
            exp_q.push_back(r);
            m_drop = 0;
            delivered = 1;
          end
          m_seq = (m_seq + 1) % 65536;
          m_cyc = 0; m_x = 0; m_s = 0; m_i = 0;
          m_act = new_win;
        end
      end
      if (delivered)                    m_pending = 1;
      else if (m_pending && res_ready)  m_pending = 0;
      m_win = new_win;
    end
  end

  // Monitor: record presence, contents/stability, and consumption
  always @(negedge clk) begin : b_monitor
    rec_t e;
    checks++;
    if (res_valid !== m_pending) begin
      errors++;
      $display("FAIL res_valid @%0t: got %0b expected %0b", $time, res_valid, m_pending);
    end
    if (res_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rec_unexpected @%0t: got seq=%0d with no record expected", $time, res_seq);
      end else begin
        e = exp_q[0];
        if (int'(res_cycles) != e.cyc || int'(res_xfers) != e.x || int'(res_stalls) != e.s ||
            int'(res_idle) != e.i || int'(res_seq) != e.seq || int'(res_dropped) != e.drop) begin
          errors++;
          $display("FAIL rec_fields @%0t: got cyc=%0d x=%0d s=%0d i=%0d seq=%0d drop=%0d expected cyc=%0d x=%0d s=%0d i=%0d seq=%0d drop=%0d",
                   $time, res_cycles, res_xfers, res_stalls, res_idle, res_seq, res_dropped,
                   e.cyc, e.x, e.s, e.i, e.seq, e.drop);
        end
        if (res_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_zero_outputs();
    chk("rst_valid",   res_valid,   0);
    chk("rst_cycles",  res_cycles,  0);
    chk("rst_xfers",   res_xfers,   0);
    chk("rst_stalls",  res_stalls,  0);
    chk("rst_idle",    res_idle,    0);
    chk("rst_seq",     res_seq,     0);
    chk("rst_dropped", res_dropped, 0);
  endtask

  task automatic load(input int len);
    window_len = WW'(len); window_len_load = 1'b1;
    tick();
    window_len_load = 1'b0;
  endtask

  task automatic run_random(input int n, input int rr_pct);
    for (int k = 0; k < n; k++) begin
      enable          = ($urandom_range(0, 99) != 0);
      window_len_load = ($urandom_range(0, 39) == 0);
      window_len      = WW'($urandom_range(0, 12));
      mon_valid       = ($urandom_range(0, 3) != 0);
      mon_ready       = 1'($urandom_range(0, 1));
      res_ready       = ($urandom_range(0, 99) < rr_pct);
      tick();
    end
  endtask

  initial begin
    tick(); tick();
    check_zero_outputs();
    nreset = 1'b1;
    tick();

    // Default window, every cycle a transfer, consumer always ready
    enable = 1; mon_valid = 1; mon_ready = 1; res_ready = 1;
    for (int k = 0; k < 2 * DEFW + 5; k++) tick();

    // Length 8, alternating transfer/stall
    load(8);
    for (int k = 0; k < 60; k++) begin
      mon_ready = k[0];
      tick();
    end

    // Length 4 with a stalled consumer: overruns and drop accounting
    mon_ready = 1;
    load(4);
    for (int k = 0; k < 8; k++) tick();
    res_ready = 0;
    for (int k = 0; k < 10; k++) tick();
    res_ready = 1;
    for (int k = 0; k < 20; k++) tick();

    // Length change mid-window, then zero length (one-cycle windows)
    load(8);
    for (int k = 0; k < 11; k++) tick();
    load(16);
    for (int k = 0; k < 40; k++) tick();
    load(0);
    for (int k = 0; k < 10; k++) tick();

    // Abort a window partway through, then resume
    load(8);
    for (int k = 0; k < 13; k++) tick();
    enable = 0;
    for (int k = 0; k < 4; k++) tick();
    enable = 1;
    for (int k = 0; k < 20; k++) tick();

    // Randomized traffic, with a mid-window reset in between
    run_random(3000, 75);
    run_random(1500, 20);
    enable = 1; mon_valid = 1; res_ready = 0;
    for (int k = 0; k < 3; k++) tick();
    nreset = 1'b0;
    model_reset();
    #1;
    check_zero_outputs();
    tick(); tick();
    nreset = 1'b1;
    run_random(3000, 60);

    // Drain
    enable = 0; res_ready = 1; window_len_load = 0;
    for (int k = 0; k < 6; k++) tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
